// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Read-side initiator for instruction_ram. Walks a PC, issues registered memRead/address
//   requests, captures the RAM's registered read data one cycle after it samples, and buffers
//   words in a small prefetch FIFO that feeds the decoder over a valid/ready handshake.
//   A branch redirect flushes every buffered and in-flight word.
//
//   Optional build macro: IFU_PERF_COUNTERS_EN adds saturating fetch_count / stall_count outputs.
module instruction_fetch_unit #(
    parameter int                           ADDRESS_BUS_WIDTH = 10,
    parameter int                           INSTRUCTION_WIDTH = 19,
    parameter logic [ADDRESS_BUS_WIDTH-1:0] RESET_PC          = 10'h200,
    parameter int                           FIFO_DEPTH        = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    output logic [ADDRESS_BUS_WIDTH-1:0] address,
    output logic                         memRead,
    output logic                         memWrite,
    input  logic [INSTRUCTION_WIDTH-1:0] data,
    input  logic                         halt,
    input  logic                         redirect_valid,
    input  logic [ADDRESS_BUS_WIDTH-1:0] redirect_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [INSTRUCTION_WIDTH-1:0] instr_data,
`ifdef IFU_PERF_COUNTERS_EN
    output logic [31:0]                  fetch_count,
    output logic [31:0]                  stall_count,
`endif
    output logic [ADDRESS_BUS_WIDTH-1:0] instr_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,  // issuing allowed
        HOLD  = 2'd1,  // halted or out of FIFO credit
        FLUSH = 2'd2   // redirect cycle: drop everything, load new pc
    } fetch_state_t;

    fetch_state_t fetch_state;

    logic [ADDRESS_BUS_WIDTH-1:0] pc;

    // Second pipeline stage: the RAM has sampled this request and data is on the bus.
    // The first stage is memRead/address themselves.
    logic                         s1_valid;
    logic                         s1_discard;
    logic [ADDRESS_BUS_WIDTH-1:0] s1_pc;

    logic [INSTRUCTION_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDRESS_BUS_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [CNT_W-1:0]             fifo_count;

    logic [1:0]                   inflight;
    logic [CNT_W:0]               occupancy;
    logic                         credit_ok;
    logic                         issue;
    logic                         flush;
    logic                         push;
    logic                         pop;

    assign memWrite    = 1'b0;
    assign instr_valid = (fifo_count != '0);
    assign instr_data  = instr_valid ? fifo_data[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;

    // Credit check: buffered words plus words still travelling through the RAM must fit.
    assign inflight  = {1'b0, memRead} + {1'b0, s1_valid};
    assign occupancy = {1'b0, fifo_count} + {{(CNT_W-1){1'b0}}, inflight};
    assign credit_ok = occupancy < (CNT_W+1)'(FIFO_DEPTH);

    // Per-cycle fetch mode with priority redirect > halt > credit, and the strobes it implies.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        fetch_state = RUN;
        if (redirect_valid) begin
            fetch_state = FLUSH;
        end else if (halt || !credit_ok) begin
            fetch_state = HOLD;
        end
        issue = (fetch_state == RUN);
        flush = (fetch_state == FLUSH);
        // A redirect voids both the returning word and any consumer pop in the same cycle.
        push  = s1_valid && !s1_discard && !flush;
        pop   = instr_valid && instr_ready && !flush;
    end

    // Issue stage and pc walk; the second stage follows the first one edge later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples
            // pre-edge values regardless of statement order.
            pc         <= RESET_PC;
            address    <= RESET_PC;
            memRead    <= 1'b0;
            s1_valid   <= 1'b0;
            s1_discard <= 1'b0;
            s1_pc      <= '0;
        end else begin
            s1_valid <= memRead;
            s1_pc    <= address;
            // The request in stage one during a redirect is already committed to the RAM;
            // tag it so its data is dropped. The one in stage two is blocked by flush itself.
            s1_discard <= flush;
            if (issue) begin
                memRead <= 1'b1;
                address <= pc;
                pc      <= pc + ADDRESS_BUS_WIDTH'(4);
            end else begin
                memRead <= 1'b0;
            end
            if (flush) begin
                pc <= redirect_pc & ~ADDRESS_BUS_WIDTH'(3);
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; fifo_count gates every read, so stale entries are never seen.
        if (push) begin
            fifo_data[wr_ptr] <= data;
            fifo_pc[wr_ptr]   <= s1_pc;
        end
    end

`ifdef IFU_PERF_COUNTERS_EN
    // Saturating counters: accepted pops, and cycles the consumer starved while not halted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (pop && (fetch_count != '1)) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (instr_ready && !instr_valid && !halt && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
//   Directed bench: registered-read RAM model, linear stimulus, hand-computed expectations.
//   Build with IFU_PERF_COUNTERS_EN defined to also exercise the performance counters.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  address;
    logic        memRead;
    logic        memWrite;
    logic [18:0] data;
    logic        halt;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [18:0] instr_data;
    logic [9:0]  instr_pc;
`ifdef IFU_PERF_COUNTERS_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int vectors    = 0;
    int miscompares = 0;

    instruction_fetch_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .memRead       (memRead),
        .memWrite      (memWrite),
        .data          (data),
        .halt          (halt),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
`ifdef IFU_PERF_COUNTERS_EN
        .fetch_count   (fetch_count),
        .stall_count   (stall_count),
`endif
        .instr_pc      (instr_pc)
    );

    always #5 clk = ~clk;

    // RAM model: 256 words indexed by address[9:2], registered read on memRead.
    // Unprogrammed word i holds 0x70000 | i so every location is distinguishable.
    logic [18:0] ram [256];
    logic [18:0] ram_q = '0;
    assign data = ram_q;
    always @(posedge clk) if (memRead) ram_q <= ram[address[9:2]];

    logic [18:0] prog [6] = '{19'h20100, 19'h20200, 19'h0830A, 19'h05600, 19'h08A01, 19'h34BFD};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        for (int i = 0; i < 256; i++) ram[i] = 19'h70000 | 19'(i);
        for (int i = 0; i < 6; i++) ram[8'h80 + i] = prog[i];
        ram[8'hFF] = 19'h12345;

        reset_n = 1'b0; instr_ready = 1'b1; halt = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        tick(); tick();

        // Reset state
        check("rst_address", 32'(address), 32'h200);
        check("rst_memRead", 32'(memRead), 32'h0);
        check("rst_memWrite", 32'(memWrite), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_data", 32'(instr_data), 32'h0);
        check("rst_pc", 32'(instr_pc), 32'h0);

        // 1: streaming fetch, first word 3 edges after reset release
        reset_n = 1'b1;
        tick();
        check("t1_e1_memRead", 32'(memRead), 32'h1);
        check("t1_e1_address", 32'(address), 32'h200);
        check("t1_e1_valid", 32'(instr_valid), 32'h0);
        tick();
        check("t1_e2_address", 32'(address), 32'h204);
        check("t1_e2_valid", 32'(instr_valid), 32'h0);
        tick();
        for (int i = 0; i < 6; i++) begin
            check("t1_valid", 32'(instr_valid), 32'h1);
            check("t1_pc", 32'(instr_pc), 32'h200 + 32'(4 * i));
            check("t1_data", 32'(instr_data), 32'(prog[i]));
            tick();
        end

        // Asynchronous reset mid-run
        reset_n = 1'b0;
        #1;
        check("arst_address", 32'(address), 32'h200);
        check("arst_memRead", 32'(memRead), 32'h0);
        check("arst_valid", 32'(instr_valid), 32'h0);
        check("arst_pc", 32'(instr_pc), 32'h0);

        // 2: consumer stalled -> exactly FIFO_DEPTH reads, head stable, then in-order drain
        instr_ready = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (memRead) pulses++;
        end
        check("t2_pulses", 32'(pulses), 32'd4);
        check("t2_head_pc", 32'(instr_pc), 32'h200);
        check("t2_head_data", 32'(instr_data), 32'h20100);
        tick(); tick();
        check("t2_stable_pc", 32'(instr_pc), 32'h200);
        check("t2_stable_memRead", 32'(memRead), 32'h0);
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t2_drain_valid", 32'(instr_valid), 32'h1);
            check("t2_drain_pc", 32'(instr_pc), 32'h200 + 32'(4 * i));
            check("t2_drain_data", 32'(instr_data), 32'(prog[i]));
            tick();
        end

        // 3: redirect to 0x20F with two reads in flight
        redirect_valid = 1'b1; redirect_pc = 10'h20F;
        tick();
        redirect_valid = 1'b0;
        check("t3_f0_valid", 32'(instr_valid), 32'h0);
        check("t3_f0_memRead", 32'(memRead), 32'h0);
        tick();
        check("t3_f1_memRead", 32'(memRead), 32'h1);
        check("t3_f1_address", 32'(address), 32'h20C);
        check("t3_f1_valid", 32'(instr_valid), 32'h0);
        tick();
        check("t3_f2_valid", 32'(instr_valid), 32'h0);
        tick();
        check("t3_f3_pc", 32'(instr_pc), 32'h20C);
        check("t3_f3_data", 32'(instr_data), 32'h05600);
        tick();
        check("t3_f4_pc", 32'(instr_pc), 32'h210);
        check("t3_f4_data", 32'(instr_data), 32'h08A01);

        // 4: halt for 8 cycles, two in-flight words still land, then resume at 0x21C
        halt = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("t4_memRead", 32'(memRead), 32'h0);
            check("t4_valid", 32'(instr_valid), (k <= 2) ? 32'h1 : 32'h0);
            if (k == 1) check("t4_w1_data", 32'(instr_data), 32'h34BFD);
            if (k == 2) check("t4_w2_pc", 32'(instr_pc), 32'h218);
        end
        halt = 1'b0;
        tick();
        check("t4_resume_memRead", 32'(memRead), 32'h1);
        check("t4_resume_address", 32'(address), 32'h21C);
        tick(); tick();
        check("t4_resume_pc", 32'(instr_pc), 32'h21C);
        check("t4_resume_data", 32'(instr_data), 32'h70087);

        // 5: redirect during halt to 0x3FF (low bits ignored), then wrap 0x3FC -> 0x000
        halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 10'h3FF;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t5_halt_valid", 32'(instr_valid), 32'h0);
            check("t5_halt_memRead", 32'(memRead), 32'h0);
            if (k < 2) tick();
        end
        halt = 1'b0;
        tick();
        check("t5_address_3fc", 32'(address), 32'h3FC);
        tick();
        check("t5_address_wrap", 32'(address), 32'h000);
        tick();
        check("t5_pc_3fc", 32'(instr_pc), 32'h3FC);
        check("t5_data_3fc", 32'(instr_data), 32'h12345);
        tick();
        check("t5_pc_000", 32'(instr_pc), 32'h000);
        check("t5_data_000", 32'(instr_data), 32'h70000);

`ifdef IFU_PERF_COUNTERS_EN
        // 6: three starved cycles after reset, six pops, then reset clears both counters
        reset_n = 1'b0;
        #1;
        tick();
        instr_ready = 1'b1;
        reset_n = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        instr_ready = 1'b0;
        check("t6_fetch_count", fetch_count, 32'd6);
        check("t6_stall_count", stall_count, 32'd3);
        tick(); tick();
        check("t6_fetch_hold", fetch_count, 32'd6);
        check("t6_stall_hold", stall_count, 32'd3);
        reset_n = 1'b0;
        #1;
        check("t6_fetch_rst", fetch_count, 32'd0);
        check("t6_stall_rst", stall_count, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
